hilo_mul_unit: RTL and testbench

//  Execute-stage consumer of the HI/LO command group produced by the control decoder (MTHI, MTLO,

---
 rtl/hilo_mul_unit.sv | 128 ++++++++++++
 tb/tb_hilo_mul_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mul_unit.sv
// HI/LO register file with a multi-cycle signed radix-2 shift-add multiplier.
// Dependent HI/LO commands presented while a multiply is in flight raise Stall.
module hilo_mul_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter logic [4:0]  MUL_CODE = 5'b10110
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Valid,
  input  logic             MTHI,
  input  logic             MTLO,
  input  logic             MFHI,
  input  logic             MFLO,
  input  logic [4:0]       ALUCtr,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Hi_out,
  output logic [WIDTH-1:0] Lo_out,
  output logic [WIDTH-1:0] Rd_out,
  output logic             Busy,
  output logic             Stall
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic              neg_q, neg_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              mul_code;
  logic              mul, wr_hi, wr_lo, rd;
  logic [WIDTH-1:0]  a_abs, b_abs;
  logic [PW-1:0]     product;

  // A MULT is encoded as MTHI&MTLO with the multiply ALU code; only then are the
  // two strobes not plain register writes.
  assign mul_code = MTHI & MTLO & (ALUCtr == MUL_CODE);
  assign mul      = Valid & mul_code;
  assign wr_hi    = Valid & MTHI & ~mul_code;
  assign wr_lo    = Valid & MTLO & ~mul_code;
  assign rd       = Valid & (MFHI | MFLO);

  // -2^(W-1) negates to itself, which read unsigned is the correct magnitude.
  assign a_abs   = A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
  assign b_abs   = B[WIDTH-1] ? (~B + WIDTH'(1)) : B;
  assign product = neg_q ? (~acc_q + PW'(1)) : acc_q;

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (mul) begin
          mcand_d  = {{WIDTH{1'b0}}, a_abs};
          mplier_d = b_abs;
          neg_d    = A[WIDTH-1] ^ B[WIDTH-1];
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end else begin
          if (wr_hi) hi_d = A;
          if (wr_lo) lo_d = A;
        end
      end
      S_RUN: begin
        // Multiplicand and multiplier shift each step so bit cnt is always at LSB.
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIN;
      end
      S_FIN: begin
        hi_d    = product[PW-1:WIDTH];
        lo_d    = product[WIDTH-1:0];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign Busy   = (state_q != S_IDLE);
  assign Stall  = Busy & (mul | wr_hi | wr_lo | rd);
  assign Hi_out = hi_q;
  assign Lo_out = lo_q;
  assign Rd_out = MFHI ? hi_q : (MFLO ? lo_q : '0);

endmodule

// File: tb/tb_hilo_mul_unit.sv
// Directed and randomized checks of hilo_mul_unit against a plain-arithmetic HI/LO model.
module tb_hilo_mul_unit;

  localparam int unsigned W        = 32;
  localparam logic [4:0]  MUL_CODE = 5'b10110;

  logic          clk = 1'b0;
  logic          rst;
  logic          Valid, MTHI, MTLO, MFHI, MFLO;
  logic [4:0]    ALUCtr;
  logic [W-1:0]  A, B;
  logic [W-1:0]  Hi_out, Lo_out, Rd_out;
  logic          Busy, Stall;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;

  hilo_mul_unit #(.WIDTH(W), .MUL_CODE(MUL_CODE)) dut (
    .clk(clk), .rst(rst), .Valid(Valid), .MTHI(MTHI), .MTLO(MTLO),
    .MFHI(MFHI), .MFLO(MFLO), .ALUCtr(ALUCtr), .A(A), .B(B),
    .Hi_out(Hi_out), .Lo_out(Lo_out), .Rd_out(Rd_out), .Busy(Busy), .Stall(Stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear();
    Valid = 1'b0; MTHI = 1'b0; MTLO = 1'b0; MFHI = 1'b0; MFLO = 1'b0;
    ALUCtr = '0; A = '0; B = '0;
  endtask

  task automatic model_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    hi_m = p[63:32];
    lo_m = p[31:0];
  endtask

  // Issues a MULT, checks Busy for the whole flight and the final HI/LO.
  // With poke set, a MTHI is presented mid-flight and must stall and be dropped.
  task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
    Valid = 1'b1; MTHI = 1'b1; MTLO = 1'b1; ALUCtr = MUL_CODE; A = a; B = b;
    #1 chk("stall_on_issue", Stall, 0);
    step();
    clear();
    chk("busy_after_issue", Busy, 1);
    for (int i = 0; i < W; i++) begin
      if (poke && i == 5) begin
        Valid = 1'b1; MTHI = 1'b1; A = $urandom;
        #1 chk("stall_mthi_busy", Stall, 1);
      end
      step();
      clear();
      chk("busy_run", Busy, 1);
    end
    chk("hi_hold_in_flight", Hi_out, hi_m);
    step();
    model_mul(a, b);
    chk("busy_done", Busy, 0);
    chk("mul_hi", Hi_out, hi_m);
    chk("mul_lo", Lo_out, lo_m);
  endtask

  task automatic write_reg(input bit to_hi, input logic [W-1:0] v);
    Valid = 1'b1; A = v;
    if (to_hi) MTHI = 1'b1; else MTLO = 1'b1;
    #1 chk("stall_write_idle", Stall, 0);
    step();
    clear();
    if (to_hi) hi_m = v; else lo_m = v;
    chk("wr_hi", Hi_out, hi_m);
    chk("wr_lo", Lo_out, lo_m);
  endtask

  initial begin
    int stall_cycles;
    logic [W-1:0] ra, rb;

    clear();
    rst = 1'b1;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    chk("rst_hi", Hi_out, 0);
    chk("rst_lo", Lo_out, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_stall", Stall, 0);

    // 1, 2: directed products including the signed edges
    run_mult(32'd7, 32'hFFFF_FFFD, 1'b0);
    chk("mul_7x-3_hi", Hi_out, 32'hFFFF_FFFF);
    chk("mul_7x-3_lo", Lo_out, 32'hFFFF_FFEB);
    run_mult(32'h8000_0000, 32'h8000_0000, 1'b1);
    chk("mul_min_hi", Hi_out, 32'h4000_0000);
    chk("mul_min_lo", Lo_out, 32'h0000_0000);
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("mul_m1_hi", Hi_out, 32'h0);
    chk("mul_m1_lo", Lo_out, 32'h1);

    // 3: plain moves and reads
    write_reg(1'b1, 32'h0000_1234);
    write_reg(1'b0, 32'hCAFE_F00D);
    Valid = 1'b1; MFHI = 1'b1;
    #1 chk("mfhi_rd", Rd_out, 32'h1234);
    chk("mfhi_stall", Stall, 0);
    MFHI = 1'b0; MFLO = 1'b1;
    #1 chk("mflo_rd", Rd_out, 32'hCAFE_F00D);
    clear();

    // MTHI alone with the multiply code is still a plain write
    Valid = 1'b1; MTHI = 1'b1; ALUCtr = MUL_CODE; A = 32'h5555_AAAA;
    step();
    clear();
    hi_m = 32'h5555_AAAA;
    chk("mthi_mulcode_hi", Hi_out, hi_m);
    chk("mthi_mulcode_busy", Busy, 0);

    // 4: MFLO right behind a MULT stalls until the product lands
    Valid = 1'b1; MTHI = 1'b1; MTLO = 1'b1; ALUCtr = MUL_CODE; A = 32'd5; B = 32'd6;
    step();
    clear();
    Valid = 1'b1; MFLO = 1'b1;
    stall_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!Stall) break;
      stall_cycles++;
      step();
    end
    model_mul(32'd5, 32'd6);
    chk("mflo_stall_cycles", stall_cycles, W + 1);
    chk("mflo_after_mul", Rd_out, 32'h1E);
    chk("stall_released", Stall, 0);
    chk("hi_after_5x6", Hi_out, hi_m);
    clear();

    // 5: reset in the middle of a multiply
    write_reg(1'b1, 32'hDEAD_BEEF);
    Valid = 1'b1; MTHI = 1'b1; MTLO = 1'b1; ALUCtr = MUL_CODE; A = 32'd100; B = 32'd100;
    step();
    clear();
    repeat (10) step();
    chk("busy_before_rst", Busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    hi_m = '0; lo_m = '0;
    chk("abort_busy", Busy, 0);
    chk("abort_hi", Hi_out, 0);
    chk("abort_lo", Lo_out, 0);
    repeat (33) step();
    chk("abort_late_hi", Hi_out, 0);
    chk("abort_late_lo", Lo_out, 0);
    chk("abort_late_busy", Busy, 0);

    // 6: commands on a bubble are ignored
    write_reg(1'b0, 32'h0BAD_F00D);
    MTHI = 1'b1; MTLO = 1'b1; ALUCtr = MUL_CODE; A = 32'h1111_2222; B = 32'h3;
    #1 chk("bubble_stall", Stall, 0);
    step();
    MTLO = 1'b0; ALUCtr = '0;
    step();
    clear();
    chk("bubble_busy", Busy, 0);
    chk("bubble_hi", Hi_out, hi_m);
    chk("bubble_lo", Lo_out, lo_m);

    // randomized mix of multiplies and moves
    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 15);
      case ($urandom_range(0, 3))
        0, 1: run_mult(ra, rb, bit'($urandom_range(0, 1)));
        2:    write_reg(1'b1, ra);
        default: write_reg(1'b0, ra);
      endcase
      Valid = 1'b1; MFHI = 1'b1;
      #1 chk("rand_mfhi", Rd_out, hi_m);
      MFHI = 1'b0; MFLO = 1'b1;
      #1 chk("rand_mflo", Rd_out, lo_m);
      clear();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
